// File: rtl/bus_timer_slave.sv
// Bus slave port wrapping an interval timer.
// A single-word access is accepted from IDLE, then held for WAIT_STATES
// cycles, then completed with a one-cycle ready pulse. The timer has
// CTRL/INTR/EXPR/COUNT registers and raises a level interrupt.
module bus_timer_slave #(
    parameter int WAIT_STATES = 1,
    parameter int BUS_ADDR    = 32,
    parameter int BUS_DATA    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_c_en,
    input  logic                  i_addr_strobe,
    input  logic [BUS_ADDR-1:0]   i_addr,
    input  logic [BUS_DATA-1:0]   i_wr_data,
    input  logic                  i_we,
    input  logic [BUS_DATA/8-1:0] i_sel,
    output logic [BUS_DATA-1:0]   o_rd_data,
    output logic                  o_ready,
    output logic                  o_irq
);

    localparam int NB = BUS_DATA / 8;
    // Last value of the wait counter before moving to RESP.
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_INTR  = 2'd1;
    localparam logic [1:0] A_EXPR  = 2'd2;
    localparam logic [1:0] A_COUNT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_wcnt;
    logic                r_ready;
    logic [1:0]          r_addr;
    logic [BUS_DATA-1:0] r_wdata;
    logic                r_we;
    logic [NB-1:0]       r_sel;

    logic                r_start;
    logic                r_periodic;
    logic                r_irq_en;
    logic                r_flag;
    logic [BUS_DATA-1:0] r_expr;
    logic [BUS_DATA-1:0] r_count;

    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_clr_flag;
    logic                w_wr_expr;
    logic                w_wr_count;
    logic                w_hit;
    logic [BUS_DATA-1:0] w_mask;
    logic [BUS_DATA-1:0] w_rd;
    logic                w_unused_addr;

    // Only addr[3:2] selects a register; the rest of the address is ignored.
    assign w_unused_addr = ^{i_addr[BUS_ADDR-1:4], i_addr[1:0]};

    // Access sequencer: capture in IDLE, count wait states, pulse ready in RESP.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            r_ready <= 1'b0;
            r_addr  <= 2'd0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (i_c_en && i_addr_strobe) begin
                        r_addr  <= i_addr[3:2];
                        r_wdata <= i_wr_data;
                        r_we    <= i_we;
                        r_sel   <= i_sel;
                        r_wcnt  <= 4'd0;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == WS_LAST) begin
                        r_wcnt  <= 4'd0;
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Writes commit on the edge that ends RESP.
    assign w_wr       = (r_state == S_RESP) && r_we;
    assign w_wr_ctrl  = w_wr && (r_addr == A_CTRL) && r_sel[0];
    assign w_clr_flag = w_wr && (r_addr == A_INTR) && r_sel[0] && r_wdata[0];
    assign w_wr_expr  = w_wr && (r_addr == A_EXPR);
    assign w_wr_count = w_wr && (r_addr == A_COUNT);
    assign w_hit      = r_start && (r_count == r_expr);

    // Expand byte enables to a bit mask for partial-word writes.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_mask[8*i +: 8] = {8{r_sel[i]}};
        end
    end

    // CTRL: a bus write takes priority over the one-shot auto-clear of START.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_start    <= 1'b0;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_start    <= r_wdata[0];
            r_periodic <= r_wdata[1];
            r_irq_en   <= r_wdata[2];
        end else if (w_hit && !r_periodic) begin
            r_start <= 1'b0;
        end
    end

    // FLAG: expiry sets it and beats a simultaneous write-1-to-clear.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_flag <= 1'b0;
        end else if (w_hit) begin
            r_flag <= 1'b1;
        end else if (w_clr_flag) begin
            r_flag <= 1'b0;
        end
    end

    // EXPR: byte-masked write.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_expr <= '0;
        end else if (w_wr_expr) begin
            r_expr <= (r_wdata & w_mask) | (r_expr & ~w_mask);
        end
    end

    // COUNT: a bus write overrides the timer; otherwise count, reload or hold.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= (r_wdata & w_mask) | (r_count & ~w_mask);
        end else if (r_start) begin
            if (w_hit) begin
                if (r_periodic) begin
                    r_count <= '0;
                end
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Read data shows the live register value during RESP and is 0 otherwise.
    always_comb begin
        w_rd = '0;
        if (r_ready && !r_we) begin
            case (r_addr)
                A_CTRL: begin
                    w_rd[0] = r_start;
                    w_rd[1] = r_periodic;
                    w_rd[2] = r_irq_en;
                end
                A_INTR:  w_rd[0] = r_flag;
                A_EXPR:  w_rd    = r_expr;
                A_COUNT: w_rd    = r_count;
                default: w_rd    = '0;
            endcase
        end
    end

    assign o_rd_data = w_rd;
    assign o_ready   = r_ready;
    assign o_irq     = r_flag & r_irq_en;

endmodule

// File: doc/bus_timer_slave.md
# bus_timer_slave

Bus responder for the shared system bus. Sits on one slave port behind the address decoder and slave read mux. Accepts single-word read/write accesses qualified by the decoder's chip enable, inserts a programmable number of wait states, and returns read data with a one-cycle `ready` pulse. The register file behind the port is an interval timer that raises a level interrupt.

## Interface
- `WAIT_STATES`, default 1: extra cycles between request acceptance and `ready`; legal range 0–15.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `c_en` input 1: chip enable from the address decoder for this slave.
- `addr_strobe` input 1: access request from the bus mux.
- `addr` input `BUS_ADDR` (32): byte address; only `addr[3:2]` is decoded.
- `wr_data` input `BUS_DATA` (32): write data.
- `we` input 1: 1 = write, 0 = read.
- `sel` input 4: byte enables; `sel[i]` covers bits 8i+7:8i.
- `rd_data` output `BUS_DATA` (32): read data; valid only while `ready` = 1, otherwise 0.
- `ready` output 1: one-cycle access completion pulse.
- `irq` output 1: timer interrupt, level.

## Operation
- Register map (word offset `addr[3:2]`):
  - 0 CTRL: bit0 START, bit1 PERIODIC, bit2 IRQ_EN; bits 31:3 read 0.
  - 1 INTR: bit0 FLAG; writing 1 clears it, writing 0 has no effect.
  - 2 EXPR: 32-bit expiration value.
  - 3 COUNT: 32-bit counter; writable.
- Byte-enable rule: writes update only bytes with `sel[i]` = 1. For CTRL/INTR, only `sel[0]` matters.
- Access FSM states:
  - IDLE: if `c_en & addr_strobe`, capture `addr[3:2]`, `wr_data`, `we`, and `sel`.
    - Go to WAIT when `WAIT_STATES` > 0; go to RESP when `WAIT_STATES` = 0.
  - WAIT: a 4-bit counter counts `WAIT_STATES` cycles, then the FSM goes to RESP.
  - RESP: `ready` = 1. For reads, `rd_data` = the current value of the addressed register. For writes, the write commits on the clock edge that ends RESP. Then go to IDLE.
  - `addr_strobe` outside IDLE is ignored. There are no back-to-back accesses without one IDLE cycle.
- Timer, evaluated every cycle:
  - If START = 1:
    - If COUNT == EXPR: set FLAG. If PERIODIC = 1, COUNT ← 0; otherwise START ← 0 and COUNT holds.
    - Otherwise COUNT ← COUNT + 1, wrapping modulo 2^32.
  - If START = 0, COUNT holds.
- `irq` = FLAG & IRQ_EN, registered-free: combinational from the flops.
- Simultaneous events, resolved in the same cycle:
  - A bus write to COUNT overrides the timer increment/reload.
  - A bus write to CTRL overrides the auto-clear of START.
  - Hardware set of FLAG wins over a write-1-to-clear.
- Reset mid-access: the pending access is dropped with no `ready` pulse, and the FSM returns to IDLE.

## Timing
- Reset values: `ready` = 0, `rd_data` = 0, `irq` = 0, CTRL = 0, FLAG = 0, EXPR = 0, COUNT = 0, FSM = IDLE, wait counter = 0.
- A request sampled in IDLE at edge T gives `ready` high during cycle T + 1 + `WAIT_STATES`.
  - `WAIT_STATES` = 0: `ready` in the cycle immediately after acceptance.
- `ready` is high for exactly one cycle per accepted access and never high without an accepted access.
- Register write effect is visible on the edge ending RESP.
  - Example: the timer starts counting the cycle after the CTRL write's RESP.
- Expiry: with START set and COUNT reaching EXPR, FLAG and `irq` rise one edge later.
- EXPR = 0 with PERIODIC = 1 gives FLAG set every cycle.

## Test plan
- Reset/idle: hold `rst` = 0, then release with no strobe. Require `ready` = 0, `rd_data` = 0, `irq` = 0, and all four registers read 0.
- Latency sweep: for `WAIT_STATES` = 0, 1, and 3, write EXPR = 0x0000_00FF then read it back.
  - `ready` must pulse exactly at T + 1, T + 2, and T + 4 respectively.
  - The read must return 0x0000_00FF.
- Byte enables: write 0xAABBCCDD to EXPR with `sel` = 4'b0101 over an initial 0. Readback must be 0x00BB00DD.
- One-shot: set EXPR = 5, COUNT = 0, CTRL = 3'b101.
  - FLAG and `irq` rise 6 cycles after START takes effect.
  - START reads 0 and COUNT stays 5.
  - Writing INTR = 1 drops `irq` the cycle after RESP.
- Periodic plus collision: set EXPR = 3 and CTRL = 3'b111.
  - Check that COUNT sequences 0, 1, 2, 3, 0, … with FLAG set at each wrap.
  - Time a write-1-to-clear of INTR to the expiry cycle; FLAG must stay 1.
- Reset mid-access: assert `rst` during WAIT of a write to EXPR with `WAIT_STATES` = 3. Require no `ready` pulse and EXPR = 0 afterwards.
